alu_sequencer: RTL and testbench

Multi-cycle issue/capture stage sitting directly upstream of the 32-bit combinational ALU in the execute path. It accepts one decoded operation per valid/ready handshake and drives the ALU's operand and control inputs from registers. It captures the ALU result and carry into a held output register, with flags derived from that result. Operations the ALU cannot do in one pass (SUB) are sequenced as two ALU passes.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU and its issue/capture sequencer.
// Op codes follow the ALU's control encoding; bit 3 selects the immediate shift amount.
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_NEG = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b0110;
    localparam logic [3:0] OP_SUB = 4'b0111;

    localparam int OP_IMM_BIT = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_SUB2 = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // SUB has no single ALU pass, so both the register and immediate variants decode to it
    function automatic logic is_sub_op(input logic [3:0] op);
        return op[OP_IMM_BIT-1:0] == OP_SUB[OP_IMM_BIT-1:0];
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Issue/capture stage in front of the combinational ALU: registers operands and control,
// sequences SUB as NEG-then-ADD, and holds the result with derived flags until consumed.
module alu_sequencer #(
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [4:0]        in_shamt,

    output logic [DATA_W-1:0] alu_inp1,
    output logic [DATA_W-1:0] alu_inp2,
    output logic [4:0]        alu_shamt,
    output logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_carry,
    output logic              out_neg,
    output logic              out_zero,
    output logic [2:0]        flags
);
    import alu_pkg::*;

    state_t state_q;
    state_t state_d;

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] neg_b_q;
    logic [3:0]        op_q;
    logic [4:0]        shamt_q;
    logic [3:0]        ctrl_q;

    logic [DATA_W-1:0] result_q;
    logic              carry_q;
    logic              neg_q;
    logic              zero_q;
    logic [2:0]        flags_q;

    logic accept;
    logic capture;
    logic handshake;
    logic op_is_sub;

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign handshake = out_valid && out_ready;
    assign op_is_sub = is_sub_op(op_q);
    assign capture   = ((state_q == ST_EXEC) && !op_is_sub) || (state_q == ST_SUB2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = op_is_sub ? ST_SUB2 : ST_DONE;
            ST_SUB2: state_d = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    state_d = in_valid ? ST_EXEC : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand/control registers; in_* is only looked at on the accept edge
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            neg_b_q <= '0;
            op_q    <= '0;
            shamt_q <= '0;
            ctrl_q  <= '0;
        end else if (accept) begin
            a_q     <= in_a;
            b_q     <= in_b;
            op_q    <= in_op;
            shamt_q <= in_shamt;
            ctrl_q  <= is_sub_op(in_op) ? OP_NEG : in_op;
        end else if ((state_q == ST_EXEC) && op_is_sub) begin
            neg_b_q <= alu_out;
            ctrl_q  <= OP_ADD;
        end
    end

    // Second SUB pass feeds the negated B back in place of B
    assign alu_inp1  = a_q;
    assign alu_inp2  = (state_q == ST_SUB2) ? neg_b_q : b_q;
    assign alu_shamt = shamt_q;
    assign alu_ctrl  = ctrl_q;

    // Result register loads only on the final pass and holds through backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            flags_q  <= 3'b000;
        end else begin
            if (capture) begin
                result_q <= alu_out;
                carry_q  <= ((state_q == ST_SUB2) || (op_q == OP_ADD)) ? alu_carry : 1'b0;
                neg_q    <= alu_out[DATA_W-1];
                zero_q   <= (alu_out == '0);
            end
            if (handshake) begin
                flags_q <= {carry_q, neg_q, zero_q};
            end
        end
    end

    assign out_result = result_q;
    assign out_carry  = carry_q;
    assign out_neg    = neg_q;
    assign out_zero   = zero_q;
    assign flags      = flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU closing the loop on the alu_* ports.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_shamt;
    logic [31:0] alu_inp1;
    logic [31:0] alu_inp2;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_out;
    logic        alu_carry;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_carry;
    logic        out_neg;
    logic        out_zero;
    logic [2:0]  flags;

    int errors = 0;
    int checks = 0;

    alu_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_shamt   (in_shamt),
        .alu_inp1   (alu_inp1),
        .alu_inp2   (alu_inp2),
        .alu_shamt  (alu_shamt),
        .alu_ctrl   (alu_ctrl),
        .alu_out    (alu_out),
        .alu_carry  (alu_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_neg    (out_neg),
        .out_zero   (out_zero),
        .flags      (flags)
    );

    always #5 clk = ~clk;

    // Behavioural ALU returning {carry, result}
    function automatic logic [32:0] alu_ref(input logic [3:0] ctrl, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] r;
        logic [32:0] sum;
        r = a;
        case (ctrl)
            4'b0000: begin sum = {1'b0, a} + {1'b0, b}; return sum; end
            4'b0001: r = ~b + 32'd1;
            4'b0010: r = a & b;
            4'b0011: r = a ^ b;
            4'b0100: r = a << b[4:0];
            4'b0101: r = a >> b[4:0];
            4'b0110: r = $signed(a) >>> b[4:0];
            4'b1100: r = a << sh;
            4'b1101: r = a >> sh;
            4'b1110: r = $signed(a) >>> sh;
            default: r = a;
        endcase
        return {1'b0, r};
    endfunction

    assign {alu_carry, alu_out} = alu_ref(alu_ctrl, alu_inp1, alu_inp2, alu_shamt);

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Entered at a negedge; returns at the negedge of the EXEC cycle with inputs scrambled
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh);
        int waited = 0;
        in_op = op; in_a = a; in_b = b; in_shamt = sh; in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        in_shamt = 5'($urandom);
        in_op = 4'($urandom);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        c;
    } vec_t;

    vec_t vecs[9];
    int acc_cyc[9];

    initial begin
        int issued;
        int got;
        int cyc;
        int stray;

        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_shamt = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_result", out_result, 32'd0);
        checkOutput("rst_out_cnz", 32'({out_carry, out_neg, out_zero}), 32'd0);
        checkOutput("rst_flags", 32'(flags), 32'd0);
        checkOutput("rst_alu_inp1", alu_inp1, 32'd0);
        checkOutput("rst_alu_inp2", alu_inp2, 32'd0);
        checkOutput("rst_alu_ctrl_shamt", 32'({alu_ctrl, alu_shamt}), 32'd0);
        rst = 1'b0;

        // Reset asserted mid-SUB must abort without producing a result
        applyStimulus(OP_SUB, 32'd9, 32'd2, 5'd0);
        checkOutput("abort_exec_ctrl", 32'(alu_ctrl), 32'(OP_NEG));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort_flags", 32'(flags), 32'd0);
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        checkOutput("abort_no_result", 32'(stray), 32'd0);

        // ADD with wraparound: zero result, carry out
        applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
        checkOutput("add_t1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("add_t2_valid", 32'(out_valid), 32'd1);
        checkOutput("add_result", out_result, 32'h0000_0000);
        checkOutput("add_carry", 32'(out_carry), 32'd1);
        checkOutput("add_zero", 32'(out_zero), 32'd1);
        checkOutput("add_neg", 32'(out_neg), 32'd0);
        @(negedge clk);
        checkOutput("add_flags", 32'(flags), 32'b101);
        checkOutput("add_drained", 32'(out_valid), 32'd0);

        // Backpressure on an XOR result; flags must keep the ADD's value while stalled
        out_ready = 1'b0;
        applyStimulus(OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd0);
        @(negedge clk);
        checkOutput("bp_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_result", out_result, 32'h0F0F_F0F0);
        checkOutput("bp_carry", 32'(out_carry), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_hold_result", out_result, 32'h0F0F_F0F0);
            checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_flags_held", 32'(flags), 32'b101);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        checkOutput("bp_drained", 32'(out_valid), 32'd0);

        // Two-pass SUB: NEG then ADD with the negated operand
        applyStimulus(OP_SUB, 32'd5, 32'd7, 5'd0);
        checkOutput("sub_exec_ctrl", 32'(alu_ctrl), 32'b0001);
        checkOutput("sub_exec_inp2", alu_inp2, 32'd7);
        @(negedge clk);
        checkOutput("sub2_ctrl", 32'(alu_ctrl), 32'b0000);
        checkOutput("sub2_inp1", alu_inp1, 32'd5);
        checkOutput("sub2_inp2", alu_inp2, 32'hFFFF_FFF9);
        checkOutput("sub_t2_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("sub_t3_valid", 32'(out_valid), 32'd1);
        checkOutput("sub_result", out_result, 32'hFFFF_FFFE);
        checkOutput("sub_carry", 32'(out_carry), 32'd0);
        checkOutput("sub_neg", 32'(out_neg), 32'd1);
        checkOutput("sub_zero", 32'(out_zero), 32'd0);
        @(negedge clk);

        // Immediate arithmetic shift right
        applyStimulus(4'b1110, 32'h8000_0000, 32'h0000_0003, 5'd4);
        checkOutput("imm_alu_shamt", 32'(alu_shamt), 32'd4);
        checkOutput("imm_alu_ctrl", 32'(alu_ctrl), 32'b1110);
        @(negedge clk);
        checkOutput("imm_valid", 32'(out_valid), 32'd1);
        checkOutput("imm_result", out_result, alu_ref(4'b1110, 32'h8000_0000, 32'h0000_0003, 5'd4)
                    [31:0]);
        checkOutput("imm_result_hand", out_result, 32'hF800_0000);
        checkOutput("imm_carry", 32'(out_carry), 32'd0);
        @(negedge clk);

        // Back-to-back stream: first three with out_ready high, rest with random stalls
        vecs[0] = '{OP_ADD,  32'd3,          32'd4,          32'd7,          1'b0};
        vecs[1] = '{4'b1111, 32'd10,         32'd3,          32'd7,          1'b1};
        vecs[2] = '{OP_AND,  32'hFF00_FF00,  32'h0FF0_0FF0,  32'h0F00_0F00,  1'b0};
        vecs[3] = '{OP_ADD,  32'h8000_0000,  32'h8000_0000,  32'h0000_0000,  1'b1};
        vecs[4] = '{OP_SUB,  32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0};
        vecs[5] = '{OP_AND,  32'hFFFF_FFFF,  32'h1234_5678,  32'h1234_5678,  1'b0};
        vecs[6] = '{OP_ADD,  32'd1,          32'd2,          32'd3,          1'b0};
        vecs[7] = '{4'b1111, 32'd100,        32'd100,        32'd0,          1'b1};
        vecs[8] = '{OP_AND,  32'd0,          32'hFFFF_FFFF,  32'd0,          1'b0};
        issued = 0;
        got = 0;
        cyc = 0;
        while (got < 9 && cyc < 400) begin
            out_ready = (got < 3) ? 1'b1 : 1'($urandom_range(0, 1));
            if (issued < 9) begin
                in_valid = 1'b1;
                in_op = vecs[issued].op;
                in_a = vecs[issued].a;
                in_b = vecs[issued].b;
            end else begin
                in_valid = 1'b0;
                in_a = $urandom;
            end
            #1;
            if (out_valid && out_ready) begin
                checkOutput($sformatf("b2b_result_%0d", got), out_result, vecs[got].res);
                checkOutput($sformatf("b2b_carry_%0d", got), 32'(out_carry), 32'(vecs[got].c));
                got++;
            end
            if (in_valid && in_ready) begin
                acc_cyc[issued] = cyc;
                issued++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checkOutput("b2b_received", 32'(got), 32'd9);
        checkOutput("b2b_issued", 32'(issued), 32'd9);
        checkOutput("b2b_gap_add_sub", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
        checkOutput("b2b_gap_sub_and", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        checkOutput("b2b_gap_and_add", 32'(acc_cyc[3] - acc_cyc[2]), 32'd2);
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        checkOutput("b2b_no_duplicate", 32'(stray), 32'd0);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
